// File: rtl/conv_feeder_pkg.sv
// Shared constants for the convolution frame feeder: pixel/word geometry,
// kernel pattern codes, the pad-width lookup and FSM state encodings.
package conv_feeder_pkg;

  localparam int PIX_W        = 8;
  localparam int WORD_W       = 256;
  localparam int PIX_PER_WORD = 32;
  localparam int SLOT_W       = $clog2(PIX_PER_WORD);

  localparam logic [2:0] pattern_3x3 = 3'd1;
  localparam logic [2:0] pattern_5x5 = 3'd2;
  localparam logic [2:0] pattern_7x7 = 3'd3;

  localparam logic [2:0] st_idle   = 3'd0;
  localparam logic [2:0] st_toppad = 3'd1;
  localparam logic [2:0] st_pix    = 3'd2;
  localparam logic [2:0] st_botpad = 3'd3;
  localparam logic [2:0] st_drain  = 3'd4;

  // Border width each side for a kernel: (k-1)/2, unknown codes get none.
  function automatic logic [1:0] pad_width(input logic [2:0] mode);
    case (mode)
      pattern_3x3: return 2'd1;
      pattern_5x5: return 2'd2;
      pattern_7x7: return 2'd3;
      default:     return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/conv_feeder_fifo.sv
// Single-clock word FIFO; the read port is registered so rd_data/rd_valid
// appear one cycle after a pop and rd_data holds between pops.
module conv_feeder_fifo
  import conv_feeder_pkg::*;
#(
  parameter int depth = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [WORD_W-1:0]           push_data,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(depth):0]      count,
  output logic [WORD_W-1:0]           rd_data,
  output logic                        rd_valid
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;

  logic [WORD_W-1:0] mem [depth];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  always_comb begin
    full    = (count == CW'(depth));
    empty   = (count == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/conv_feeder.sv
// Packs a raster pixel stream into 32-pixel words with a kernel-sized zero
// border and hands one word to the convolution engine per request pulse.
module conv_feeder
  import conv_feeder_pkg::*;
#(
  parameter int width     = 1920,
  parameter int height    = 1080,
  parameter int fifoDepth = 4,
  parameter int pendW     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              iStart,
  input  logic [2:0]        mode,
  input  logic [PIX_W-1:0]  iPix,
  input  logic              iPixValid,
  output logic              oPixReady,
  input  logic              iReq,
  output logic [WORD_W-1:0] oData,
  output logic              oValid,
  output logic              oBusy,
  output logic              oDone,
  output logic [2:0]        dbg_state,
  output logic [pendW-1:0]  dbg_pending
);

  // Handshakes: a pixel transfers on a clock edge where iPixValid and
  // oPixReady are both high; each iReq pulse asks for one word, and every
  // word is delivered as a single-cycle oValid with oData alongside.

  localparam int COL_W = $clog2(width + 6 + PIX_PER_WORD) + 1;
  localparam int ROW_W = $clog2(height + 7) + 1;
  localparam int CNT_W = $clog2(fifoDepth) + 1;

  logic [2:0]               state;
  logic [2:0]               state_nx;
  logic [2:0]               mode_q;
  logic [1:0]               pad;
  logic [COL_W-1:0]         col;
  logic [COL_W-1:0]         row_slots;
  logic [COL_W-1:0]         pad_col;
  logic [COL_W-1:0]         pix_end;
  logic [ROW_W-1:0]         row;
  logic [ROW_W-1:0]         phase_rows;
  logic [WORD_W-PIX_W-1:0]  acc;
  logic [PIX_W-1:0]         cur_byte;
  logic                     active;
  logic                     pixel_slot;
  logic                     advance;
  logic                     word_done;
  logic                     row_end;
  logic                     phase_end;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic                     pop;
  logic                     last_pop;
  logic [pendW-1:0]         pending;

  assign pad = pad_width(mode_q);

  // Row geometry: each row is rounded up to whole words of slots.
  always_comb begin
    row_slots = COL_W'(((width + 2 * int'(pad) + PIX_PER_WORD - 1) / PIX_PER_WORD)
                       * PIX_PER_WORD);
    pad_col   = COL_W'(pad);
    pix_end   = COL_W'(width + int'(pad));
  end

  always_comb begin
    active     = (state == st_toppad) || (state == st_pix) || (state == st_botpad);
    pixel_slot = (state == st_pix) && (col >= pad_col) && (col < pix_end);
    advance    = active && !fifo_full && (!pixel_slot || iPixValid);
    cur_byte   = pixel_slot ? iPix : '0;
    word_done  = advance && (col[SLOT_W-1:0] == {SLOT_W{1'b1}});
    row_end    = advance && (col == row_slots - 1'b1);
    phase_rows = (state == st_pix) ? ROW_W'(height) : ROW_W'(pad);
    phase_end  = row_end && (row == phase_rows - 1'b1);
  end

  assign oPixReady = pixel_slot && !fifo_full;

  // Zero-height pad phases are skipped so every state entered emits rows.
  always_comb begin
    state_nx = state;
    case (state)
      st_idle:   if (iStart) state_nx = (pad_width(mode) == 2'd0) ? st_pix : st_toppad;
      st_toppad: if (phase_end) state_nx = st_pix;
      st_pix:    if (phase_end) state_nx = (pad == 2'd0) ? st_drain : st_botpad;
      st_botpad: if (phase_end) state_nx = st_drain;
      st_drain:  if (last_pop) state_nx = st_idle;
      default:   state_nx = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= st_idle;
      mode_q <= '0;
      col    <= '0;
      row    <= '0;
      acc    <= '0;
    end else begin
      state <= state_nx;
      if (state == st_idle) begin
        col <= '0;
        row <= '0;
        if (iStart) mode_q <= mode;
      end else if (advance) begin
        acc <= {acc[WORD_W-2*PIX_W-1:0], cur_byte};
        if (row_end) begin
          col <= '0;
          row <= phase_end ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Requests are remembered until a word is there to answer them.
  always_comb begin
    pop      = ((pending != '0) || iReq) && !fifo_empty;
    last_pop = (state == st_drain) && pop && (fifo_count == CNT_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= '0;
    end else if ((state != st_idle) && (state_nx == st_idle)) begin
      pending <= '0;
    end else begin
      case ({iReq, pop})
        2'b10:   if (pending != '1) pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oBusy <= (state_nx != st_idle);
      oDone <= last_pop;
    end
  end

  conv_feeder_fifo #(
    .depth(fifoDepth)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (word_done),
    .push_data({acc, cur_byte}),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .rd_data  (oData),
    .rd_valid (oValid)
  );

  assign dbg_state   = state;
  assign dbg_pending = pending;

endmodule

// File: tb/tb_conv_feeder.sv
// Bench for conv_feeder: a 40x2 instance for most scenarios and a 26x1
// instance for the 7x7 single-word-row geometry, checked against a frame model.
module tb_conv_feeder;
  import conv_feeder_pkg::*;

  localparam int W_A    = 40;
  localparam int H_A    = 2;
  localparam int W_B    = 26;
  localparam int H_B    = 1;
  localparam int DEPTH  = 4;
  localparam int PEND_W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start_a, pix_valid_a, pix_ready_a, req_a, valid_a, busy_a, done_a;
  logic [2:0]   mode_a, dbg_state_a;
  logic [7:0]   pix_a;
  logic [255:0] data_a;
  logic [PEND_W-1:0] dbg_pending_a;

  logic         start_b, pix_valid_b, pix_ready_b, req_b, valid_b, busy_b, done_b;
  logic [2:0]   mode_b, dbg_state_b;
  logic [7:0]   pix_b;
  logic [255:0] data_b;
  logic [PEND_W-1:0] dbg_pending_b;

  conv_feeder #(.width(W_A), .height(H_A), .fifoDepth(DEPTH), .pendW(PEND_W)) dut_a (
    .clk(clk), .reset(reset), .iStart(start_a), .mode(mode_a), .iPix(pix_a),
    .iPixValid(pix_valid_a), .oPixReady(pix_ready_a), .iReq(req_a), .oData(data_a),
    .oValid(valid_a), .oBusy(busy_a), .oDone(done_a), .dbg_state(dbg_state_a),
    .dbg_pending(dbg_pending_a)
  );

  conv_feeder #(.width(W_B), .height(H_B), .fifoDepth(DEPTH), .pendW(PEND_W)) dut_b (
    .clk(clk), .reset(reset), .iStart(start_b), .mode(mode_b), .iPix(pix_b),
    .iPixValid(pix_valid_b), .oPixReady(pix_ready_b), .iReq(req_b), .oData(data_b),
    .oValid(valid_b), .oBusy(busy_b), .oDone(done_b), .dbg_state(dbg_state_b),
    .dbg_pending(dbg_pending_b)
  );

  // scoreboard state
  logic [255:0] exp_q_a[$];
  logic [255:0] exp_q_b[$];
  int           ppw_q[$];
  logic [7:0]   src [0:255];
  int n_checks = 0;
  int n_errors = 0;
  int pix_idx_a, acc_a, vcount_a, dcount_a;
  int pix_idx_b, acc_b, vcount_b, dcount_b;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_src(input bit rnd);
    for (int i = 0; i < 256; i++) src[i] = rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1);
  endtask

  // Frame model straight from the slot rules: pad rows/columns are zero,
  // interior slots take the next source pixel in raster order.
  task automatic model_frame(input int w, input int h, input int p, input bit sel);
    int wpr, n, cnt, s;
    logic [255:0] word;
    wpr = (w + 2 * p + 31) / 32;
    n = 0;
    for (int r = 0; r < h + 2 * p; r++) begin
      for (int wd = 0; wd < wpr; wd++) begin
        word = '0;
        cnt = 0;
        for (int k = 0; k < 32; k++) begin
          s = wd * 32 + k;
          if (r >= p && r < p + h && s >= p && s < p + w) begin
            word[255 - 8 * k -: 8] = src[n];
            n++;
            cnt++;
          end
        end
        if (sel) exp_q_b.push_back(word);
        else begin
          exp_q_a.push_back(word);
          ppw_q.push_back(cnt);
        end
      end
    end
  endtask

  // driver tasks: present inputs at a falling edge, then observe the outputs
  // produced by the following rising edge at the next falling edge
  task automatic cycle_a(input bit v, input bit r);
    logic [255:0] w;
    pix_a = src[pix_idx_a % 256];
    pix_valid_a = v;
    req_a = r;
    if (v && pix_ready_a) begin
      pix_idx_a++;
      acc_a++;
    end
    @(negedge clk);
    if (valid_a) begin
      vcount_a++;
      check("a_word_expected", exp_q_a.size() != 0, 1);
      if (exp_q_a.size() != 0) begin
        w = exp_q_a.pop_front();
        check("a_word", data_a, w);
        check("a_done_with_last", done_a, exp_q_a.size() == 0);
      end
    end else if (done_a) begin
      check("a_done_without_valid", done_a, 0);
    end
    if (done_a) dcount_a++;
  endtask

  task automatic cycle_b(input bit v, input bit r);
    logic [255:0] w;
    pix_b = src[pix_idx_b % 256];
    pix_valid_b = v;
    req_b = r;
    if (v && pix_ready_b) begin
      pix_idx_b++;
      acc_b++;
    end
    @(negedge clk);
    if (valid_b) begin
      vcount_b++;
      check("b_word_expected", exp_q_b.size() != 0, 1);
      if (exp_q_b.size() != 0) begin
        w = exp_q_b.pop_front();
        check("b_word", data_b, w);
        check("b_done_with_last", done_b, exp_q_b.size() == 0);
      end
    end
    if (done_b) dcount_b++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start_a = 1'b0; pix_valid_a = 1'b0; req_a = 1'b0;
    start_b = 1'b0; pix_valid_b = 1'b0; req_b = 1'b0;
    exp_q_a.delete();
    ppw_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pix_idx_a = 0; acc_a = 0; vcount_a = 0; dcount_a = 0;
  endtask

  task automatic start_frame_a(input logic [2:0] m, input int p);
    model_frame(W_A, H_A, p, 1'b0);
    mode_a = m;
    start_a = 1'b1;
    cycle_a(1'b0, 1'b0);
    start_a = 1'b0;
  endtask

  initial begin
    int exp_acc;
    reset = 1'b1;
    start_a = 0; mode_a = 0; pix_a = 0; pix_valid_a = 0; req_a = 0;
    start_b = 0; mode_b = 0; pix_b = 0; pix_valid_b = 0; req_b = 0;
    pix_idx_a = 0; acc_a = 0; vcount_a = 0; dcount_a = 0;
    pix_idx_b = 0; acc_b = 0; vcount_b = 0; dcount_b = 0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_data", data_a, 0);
    check("rst_pix_ready", pix_ready_a, 0);
    check("rst_state", dbg_state_a, st_idle);
    check("rst_pending", dbg_pending_a, 0);
    reset = 1'b0;
    @(negedge clk);

    // 7x7 on a 26-wide row: exactly one word per row, 7 rows
    fill_src(1'b0);
    model_frame(W_B, H_B, 3, 1'b1);
    mode_b = pattern_7x7;
    start_b = 1'b1;
    cycle_b(1'b0, 1'b0);
    start_b = 1'b0;
    check("b_busy", busy_b, 1);
    repeat (300) cycle_b(1'b1, 1'b1);
    check("b_words", vcount_b, 7);
    check("b_done_count", dcount_b, 1);
    check("b_pixels", acc_b, W_B);
    check("b_left", exp_q_b.size(), 0);

    // 3x3 geometry, sequential pixels, requests always asserted
    do_reset();
    fill_src(1'b0);
    start_frame_a(pattern_3x3, 1);
    repeat (400) cycle_a(1'b1, 1'b1);
    check("g3_words", vcount_a, 8);
    check("g3_done_count", dcount_a, 1);
    check("g3_pixels", acc_a, 80);
    check("g3_left", exp_q_a.size(), 0);
    check("g3_idle", busy_a, 0);

    // backpressure: no requests, FIFO fills and upstream stalls
    do_reset();
    fill_src(1'b1);
    start_frame_a(pattern_3x3, 1);
    repeat (200) cycle_a(1'b1, 1'b0);
    exp_acc = 0;
    for (int i = 0; i < DEPTH; i++) exp_acc += ppw_q[i];
    check("bp_stalled_pixels", acc_a, exp_acc);
    check("bp_ready_low", pix_ready_a, 0);
    check("bp_no_words", vcount_a, 0);
    for (int i = 0; i < 8; i++) begin
      cycle_a(1'b1, 1'b1);
      check("bp_req_latency", valid_a, 1);
      cycle_a(1'b1, 1'b0);
      check("bp_single_word", valid_a, 0);
      repeat (40) cycle_a(1'b1, 1'b0);
    end
    check("bp_words", vcount_a, 8);
    check("bp_done_count", dcount_a, 1);
    check("bp_left", exp_q_a.size(), 0);

    // pending requests issued before any word exists
    do_reset();
    fill_src(1'b1);
    start_frame_a(pattern_3x3, 1);
    repeat (5) cycle_a(1'b0, 1'b1);
    check("pend_count", dbg_pending_a, 5);
    check("pend_no_words_yet", vcount_a, 0);
    repeat (300) cycle_a(1'b1, 1'b0);
    check("pend_served", vcount_a, 5);
    check("pend_drained", dbg_pending_a, 0);
    cycle_a(1'b1, 1'b1);
    check("pend_pop_latency", valid_a, 1);
    check("pend_req_with_pop", dbg_pending_a, 0);
    repeat (20) cycle_a(1'b1, 1'b1);
    check("pend_words", vcount_a, 8);
    check("pend_done_count", dcount_a, 1);
    check("pend_left", exp_q_a.size(), 0);

    // upstream gaps, random requests, a stray iStart mid-frame
    do_reset();
    fill_src(1'b1);
    start_frame_a(pattern_3x3, 1);
    for (int i = 0; i < 700; i++) begin
      if (i == 150) begin
        start_a = 1'b1;
        mode_a = pattern_7x7;
      end
      cycle_a(i % 2 == 0, $urandom_range(0, 3) == 0);
      start_a = 1'b0;
    end
    repeat (60) cycle_a(1'b0, 1'b1);
    check("gap_words", vcount_a, 8);
    check("gap_done_count", dcount_a, 1);
    check("gap_pixels", acc_a, 80);
    check("gap_left", exp_q_a.size(), 0);

    // reset in the middle of the pixel rows, then a clean p=0 frame
    do_reset();
    fill_src(1'b1);
    start_frame_a(pattern_3x3, 1);
    repeat (100) cycle_a(1'b1, 1'b1);
    check("mid_state", dbg_state_a, st_pix);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_busy", busy_a, 0);
    check("mid_rst_done", done_a, 0);
    check("mid_rst_data", data_a, 0);
    check("mid_rst_ready", pix_ready_a, 0);
    check("mid_rst_state", dbg_state_a, st_idle);
    do_reset();
    check("post_rst_done", done_a, 0);
    fill_src(1'b0);
    start_frame_a(3'b000, 0);
    repeat (300) cycle_a(1'b1, 1'b1);
    check("p0_words", vcount_a, H_A * 2);
    check("p0_done_count", dcount_a, 1);
    check("p0_pixels", acc_a, W_A * H_A);
    check("p0_left", exp_q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/conv_feeder.md
Name: conv_feeder

Overview:
- Frame-side source for the convolution engine.
- Accepts a raster 8-bit pixel stream and packs it into 256-bit words of 32 pixels each, inserting the zero border the selected kernel needs.
- Delivers one word per request pulse from the engine (the engine's oReq drives this block's iReq; this block's oData/oValid drive the engine's iData/iValid).
- Buffers words in a small FIFO so upstream and the engine stay decoupled.

Parameters:
- width, 1920: active pixels per row.
- height, 1080: active rows per frame.
- fifoDepth, 4: FIFO depth in 256-bit words; power of two, minimum 2.
- pendW, 8: width of the outstanding-request counter.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-high
- iStart  in  1  frame start pulse; sampled only in IDLE
- mode  in  3  kernel select using the shared pattern_3x3/5x5/7x7 codes; latched on iStart
- iPix  in  8  upstream pixel, raster order
- iPixValid  in  1  iPix valid
- oPixReady  out  1  pixel accepted this cycle when iPixValid is also high
- iReq  in  1  engine requests one word; one pulse per word
- oData  out  256  packed word; pixel 0 in [255:248], pixel k in [255-8k:248-8k]
- oValid  out  1  oData valid; one cycle per word
- oBusy  out  1  frame in progress
- oDone  out  1  one-cycle pulse coincident with the last word's oValid

Behaviour:
- Reset:
  - All outputs go to 0; state goes to IDLE.
  - FIFO, packer, counters and pending are cleared.
  - Reset mid-frame abandons the frame; no oDone is produced.
- Pad width p from the latched mode: 3x3 gives 1, 5x5 gives 2, 7x7 gives 3, any other code gives 0.
- Frame geometry:
  - rowLen = width+2p pixels.
  - wpr = ceil(rowLen/32) words per row.
  - Frame = (height+2p) rows × wpr words.
  - Each row is padded to wpr×32 slots: slots < p are 0, slots p..p+width-1 are pixels, slots ≥ p+width are 0.
- FSM:
  - IDLE -> TOPPAD on iStart; mode is latched and oBusy goes to 1.
  - TOPPAD emits p all-zero rows, then goes to PIX. If p=0 it goes straight to PIX.
  - PIX emits height rows, then goes to BOTPAD.
  - BOTPAD emits p zero rows, then goes to DRAIN.
  - DRAIN waits until the FIFO is empty and the last word has been output, then goes to IDLE with oBusy=0.
  - iStart outside IDLE is ignored.
- Packer:
  - Advances one slot per cycle when the FIFO is not full AND (the slot is a zero slot OR iPixValid=1).
  - oPixReady = 1 only in PIX, on a pixel slot, with the FIFO not full; this is combinational from state, counters and FIFO count.
  - Zero slots never consume upstream data.
  - The completed word is pushed into the FIFO in the same cycle as its 32nd slot.
  - If the FIFO is full, the packer stalls; there is no data loss and no bubble insertion.
- Requests:
  - pending increments on iReq and decrements on pop.
  - A pop happens when (pending>0 OR iReq) and the FIFO is not empty.
  - Simultaneous iReq and pop leaves pending unchanged.
  - pending saturates at 2^pendW-1; excess requests are dropped (protocol violation).
- Output timing:
  - oData/oValid are registered and appear 1 cycle after the pop.
  - Best case, iReq at cycle t gives oValid at t+1.
  - With an empty FIFO, the request is served on the cycle after the first word arrives.
- oData holds its last value when oValid=0.
- oDone pulses with the frame's final word. pending resets to 0 on the IDLE entry.

Decomposition:
- Shared package/params.v holds:
  - the pattern_* mode codes,
  - a pad-width function (mode -> p),
  - pixel width 8,
  - word width 256,
  - pixels per word 32.
- One sub-module, conv_feeder_fifo:
  - synchronous single-clock FIFO, 256 bits × fifoDepth;
  - push/pop/full/empty/count;
  - same asynchronous active-high reset;
  - read data is registered to form oData.
- The FSM, slot/row counters, packer and pending counter stay in the top level.

Test Plan:
- Geometry, 3x3: width=40, height=2, mode=3x3, iReq held high, pixels 1..80 always valid.
  - Required: 8 words total (4 rows × 2).
  - Words 0–1 and 6–7 are all zero.
  - Word 2: byte0=0, bytes1..31=1..31.
  - Word 3: bytes0..8=32..40, bytes9..31=0.
  - oDone coincides with word 7.
  - oPixReady is high for exactly 80 accepted cycles.
- Geometry, 7x7: width=26, height=1, mode=7x7.
  - Required: rowLen=32, wpr=1, 7 words.
  - Only word 3 carries data: bytes3..28=pixels, bytes 0..2 and 29..31 = 0.
- Backpressure: no iReq for 200 cycles after iStart.
  - Required: FIFO fills to fifoDepth, oPixReady drops to 0, upstream pixels are not consumed.
  - Subsequent single iReq pulses each give exactly one oValid 1 cycle later, with data in order.
- Pending requests: 5 iReq pulses issued before any pixel arrives, then the stream starts.
  - Required: 5 oValid pulses, each on the cycle after its word is pushed; pending ends at 0.
  - iReq coinciding with a pop leaves pending unchanged.
- Upstream gaps: iPixValid toggled in a 1010 pattern.
  - Required: word contents are identical to the gap-free run; zero slots still advance during invalid cycles.
- Reset/start corner: assert reset mid-PIX.
  - Required: outputs go to 0 immediately with no oDone.
  - iStart during busy is ignored.
  - A new iStart after reset produces a full correct frame; mode=3'b000 gives p=0 and height×wpr words.
